rotate_fram_rd_ctrl: RTL and testbench
======================================

// Module: rotate_fram_rd_ctrl
// PURPOSE
//  Read-side controller for the rotate frame buffer (16b write / 256b read SDPRAM). The buffer is run as
//  a ping-pong of two halves; the writer pulses bank_done per filled half. This block drives the 256b
//  read port, absorbs the RAM read latency in a small skid FIFO and emits valid/ready bursts to the DDR write master.
// PARAMETERS
//  RD_ADDR_WIDTH  8    buffer read address width; half size HALF = 2**(RD_ADDR_WIDTH-1) = 128 words
//  RD_DATA_WIDTH  256  read word / stream width
//  BURST_LEN      16   words per output burst; must divide HALF, power of two
// PORTS
//  rd_clk      in   1              single clock (buffer read clock domain)
//  rd_rst_n    in   1              asynchronous active-low reset
//  bank_done   in   1              1-cycle pulse: writer finished next half (halves alternate, first = 0)
//  rd_addr     out  RD_ADDR_WIDTH  buffer read address
//  rd_en       out  1              read issue strobe (data valid 1 cycle later, 2 with RD_OUT_REG_EN)
//  rd_data     in   RD_DATA_WIDTH  buffer read data
//  m_data      out  RD_DATA_WIDTH  output word
//  m_valid     out  1              output valid
//  m_ready     in   1              downstream accept
//  m_last      out  1              last word of current burst
//  bank_free   out  1              1-cycle pulse: a half fully accepted downstream, writer may reuse it
//  busy        out  1              state != IDLE or FIFO non-empty
//  ovf_err     out  1              sticky: bank_done seen with 2 halves already pending
// BEHAVIOUR
//  - Reset: rd_addr=0, rd_en=0, m_valid=0, m_last=0, m_data=0, bank_free=0, busy=0, ovf_err=0, pending=0,
//    FIFO empty, rd bank=0. Reset mid-burst discards in-flight and FIFO words; no bank_free issued.
//  - pending (0..2): +1 on bank_done, -1 on bank_free; both same cycle -> unchanged. bank_done at
//    pending=2 (and no same-cycle bank_free) -> ignored, ovf_err<=1 until reset.
//  - FSM: IDLE -> READ when pending>0; READ issues HALF sequential reads from bank*HALF;
//    after last issue -> DRAIN; DRAIN -> IDLE when last word of the half accepted (m_valid&m_ready&word==HALF-1);
//    on that cycle bank_free=1, bank toggles. Next half may start the following cycle (IDLE 1 cycle min).
//  - Issue rule: rd_en=1 only if FIFO occupancy + in-flight reads < FIFO depth (2; 3 with RD_OUT_REG_EN);
//    rd_addr increments by 1 per issue; wraps HALF-1 -> 0 within address space (bank1 ends at 2**RD_ADDR_WIDTH-1 -> 0).
//  - FIFO: written when read data returns (rd_en delayed by latency); head drives m_data/m_valid directly.
//    Simultaneous push and pop allowed; never overflows by construction (assert in sim).
//  - Handshake: m_data/m_last stable while m_valid & !m_ready; m_valid never drops without acceptance.
//  - m_last=1 on word index k where (k+1) % BURST_LEN == 0 (k = 0..HALF-1 within half).
//  - Throughput: m_ready held 1 -> one word/cycle after first-word latency of 2 cycles from READ entry
//    (3 with RD_OUT_REG_EN).
// CONFIGURATION
//  RD_OUT_REG_EN defined: buffer instantiated with output register; read latency 2, FIFO depth 3.
//  Undefined (default): read latency 1, FIFO depth 2. Ordering/handshake identical in both builds.
// TESTING
//  1. One bank_done, m_ready=1 -> 128 words on addr 0..127, data matches RAM, m_last at k=15,31..127,
//     bank_free pulse on word 127 acceptance, busy back to 0.
//  2. Two bank_done back-to-back -> 256 words contiguous, addr 0..255 then bank0 again; 2 bank_free pulses.
//  3. m_ready random 50% -> no word lost/duplicated/reordered; m_data stable under backpressure; FIFO never over depth.
//  4. Third bank_done while pending=2 -> ovf_err=1 and sticky, only 256 words produced;
//     bank_done same cycle as bank_free -> no error, pending stays 2.
//  5. rd_rst_n low at word 60 of a half -> all outputs at reset values; after release + bank_done, reads restart at addr 0.
//  6. Repeat 1-3 with RD_OUT_REG_EN defined -> identical output stream, first word 1 cycle later.

Source files
------------

// File: rtl/rotate_fram_rd_ctrl_if.sv
// Output stream from the rotate frame buffer read controller to the DDR write master.
// The controller is the master; the DDR write master is the slave.
interface rotate_fram_rd_ctrl_if #(
  parameter int unsigned RD_DATA_WIDTH = 256
) ();
  logic [RD_DATA_WIDTH-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_last;

  modport master (output m_data, output m_valid, output m_last, input  m_ready);
  modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);
endinterface

// File: rtl/rotate_fram_rd_ctrl.sv
// Read-side ping-pong controller for the rotate frame buffer: issues half-sized read runs,
// absorbs RAM latency in a skid FIFO and streams bursts out. Build option: RD_OUT_REG_EN.
module rotate_fram_rd_ctrl #(
  parameter int unsigned RD_ADDR_WIDTH = 8,
  parameter int unsigned RD_DATA_WIDTH = 256,
  parameter int unsigned BURST_LEN     = 16
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst_n,
  input  logic                     bank_done,
  output logic [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic                     rd_en,
  input  logic [RD_DATA_WIDTH-1:0] rd_data,
  rotate_fram_rd_ctrl_if.master    m_if,
  output logic                     bank_free,
  output logic                     busy,
  output logic                     ovf_err
);

  localparam int unsigned HW   = RD_ADDR_WIDTH - 1;
  localparam int unsigned HALF = 2 ** HW;
`ifdef RD_OUT_REG_EN
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 3;
`else
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 2;
`endif

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [RD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [HW-1:0]            out_idx_q;
  logic [1:0]               pending_q, pending_d;
  logic                     ovf_q, ovf_d;
  logic [LAT-1:0]           dv_q;
  logic [RD_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [1:0]               wptr_q, rptr_q, cnt_q;
  logic                     push_c, pop_c, issue_c, free_c, done_ok_c;
  logic [2:0]               inflight_c, occ_c;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign push_c         = dv_q[LAT-1];
  assign m_if.m_valid   = (cnt_q != 2'd0);
  assign m_if.m_data    = m_if.m_valid ? mem_q[rptr_q] : '0;
  assign m_if.m_last    = m_if.m_valid &&
                          ((out_idx_q & HW'(BURST_LEN - 1)) == HW'(BURST_LEN - 1));
  assign pop_c          = m_if.m_valid && m_if.m_ready;
  assign free_c         = (state_q == DRAIN) && pop_c && (out_idx_q == HW'(HALF - 1));
  assign rd_en          = issue_c;
  assign rd_addr        = addr_q;
  assign bank_free      = free_c;
  assign busy           = (state_q != IDLE) || (cnt_q != 2'd0);
  assign ovf_err        = ovf_q;

  // Reads issued but not yet landed in the FIFO
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < LAT; i++) inflight_c = inflight_c + 3'(dv_q[i]);
  end

  // Next state and read issue; a pop this cycle frees a slot for the read issued now
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue_c = 1'b0;
    occ_c   = 3'(cnt_q) + inflight_c - 3'(pop_c);
    unique case (state_q)
      IDLE:  if (pending_q != 2'd0) state_d = READ;
      READ: begin
        if (occ_c < 3'(DEPTH)) begin
          issue_c = 1'b1;
          addr_d  = addr_q + RD_ADDR_WIDTH'(1);
          if (addr_q[HW-1:0] == HW'(HALF - 1)) state_d = DRAIN;
        end
      end
      DRAIN: if (free_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pending-half bookkeeping; a done arriving with both halves pending is dropped
  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    done_ok_c = bank_done && !((pending_q == 2'd2) && !free_c);
    if (bank_done && !done_ok_c) ovf_d = 1'b1;
    unique case ({done_ok_c, free_c})
      2'b10:   pending_d = pending_q + 2'd1;
      2'b01:   pending_d = pending_q - 2'd1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      out_idx_q <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      dv_q      <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      dv_q      <= LAT'({dv_q, issue_c});
      cnt_q     <= cnt_q + 2'(push_c) - 2'(pop_c);
      if (push_c) begin
        mem_q[wptr_q] <= rd_data;
        wptr_q        <= ptr_next(wptr_q);
      end
      if (pop_c) begin
        rptr_q    <= ptr_next(rptr_q);
        out_idx_q <= out_idx_q + HW'(1);
      end
    end
  end

  fifo_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(push_c && !pop_c && (cnt_q == 2'(DEPTH))));

endmodule

// File: tb/tb_rotate_fram_rd_ctrl.sv
// Directed bench for rotate_fram_rd_ctrl: single/double halves, backpressure, overflow,
// free/done collision and mid-half reset, against a behavioural buffer model.
module tb_rotate_fram_rd_ctrl;
  localparam int HALF  = 128;
  localparam int BURST = 16;
`ifdef RD_OUT_REG_EN
  localparam int LAT_EXP = 5;
`else
  localparam int LAT_EXP = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bank_done = 1'b0;
  logic [7:0]   rd_addr;
  logic         rd_en;
  logic [255:0] rd_data;
  logic         bank_free, busy, ovf_err;
  logic [255:0] ram_q = '0;
  logic [255:0] ram_q2 = '0;

  rotate_fram_rd_ctrl_if #(.RD_DATA_WIDTH(256)) mif ();

  rotate_fram_rd_ctrl #(.RD_ADDR_WIDTH(8), .RD_DATA_WIDTH(256), .BURST_LEN(16)) dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .bank_done(bank_done), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .m_if(mif), .bank_free(bank_free), .busy(busy), .ovf_err(ovf_err));

  always #5 clk = ~clk;

  function automatic logic [255:0] ram_word(input logic [7:0] a);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = {8'(i), a, ~a, a ^ 8'h5A};
    return w;
  endfunction

  // Behavioural buffer read port
  always @(posedge clk) begin
    if (rd_en) ram_q <= ram_word(rd_addr);
    ram_q2 <= ram_q;
  end
`ifdef RD_OUT_REG_EN
  assign rd_data = ram_q2;
`else
  assign rd_data = ram_q;
`endif

  int n_chk = 0, n_err = 0;
  int stp = 0, n_acc = 0, nfree = 0, exp_k = 0;
  int first_valid = -1, last_acc = -1;
  logic [7:0] exp_addr = '0, iss_addr = '0;
  logic stall_q = 1'b0, prev_last = 1'b0, auto_used = 1'b0;
  logic [255:0] prev_data = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_trackers();
    exp_addr = '0; iss_addr = '0; exp_k = 0; stall_q = 1'b0; first_valid = -1;
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_rd_en"},     256'(rd_en), 256'(0));
    chk({tag, "_rd_addr"},   256'(rd_addr), 256'(0));
    chk({tag, "_m_valid"},   256'(mif.m_valid), 256'(0));
    chk({tag, "_m_last"},    256'(mif.m_last), 256'(0));
    chk({tag, "_m_data"},    mif.m_data, 256'(0));
    chk({tag, "_bank_free"}, 256'(bank_free), 256'(0));
    chk({tag, "_busy"},      256'(busy), 256'(0));
    chk({tag, "_ovf_err"},   256'(ovf_err), 256'(0));
  endtask

  // One clock: drive after the edge, check at the falling edge
  task automatic step(input logic rdy, input logic done, input logic auto_d);
    logic acc;
    @(posedge clk); #1;
    mif.m_ready = rdy;
    bank_done   = done;
    if (auto_d && !auto_used && mif.m_valid && rdy && exp_k == HALF - 1) begin
      bank_done = 1'b1;
      auto_used = 1'b1;
    end
    @(negedge clk);
    stp++;
    if (stall_q) begin
      chk("hold_valid", 256'(mif.m_valid), 256'(1));
      chk("hold_data",  mif.m_data, prev_data);
      chk("hold_last",  256'(mif.m_last), 256'(prev_last));
    end
    if (rd_en) begin
      chk("rd_addr", 256'(rd_addr), 256'(iss_addr));
      iss_addr++;
    end
    acc = mif.m_valid && mif.m_ready;
    chk("bank_free", 256'(bank_free), 256'(acc && exp_k == HALF - 1));
    if (acc) begin
      if (first_valid < 0) first_valid = stp;
      chk("m_data", mif.m_data, ram_word(exp_addr));
      chk("m_last", 256'(mif.m_last), 256'(((exp_k + 1) % BURST) == 0));
      if (exp_k == HALF - 1) nfree++;
      exp_addr++;
      exp_k = (exp_k + 1) % HALF;
      n_acc++;
      last_acc = stp;
    end
    stall_q   = mif.m_valid && !mif.m_ready;
    prev_data = mif.m_data;
    prev_last = mif.m_last;
  endtask

  task automatic collect(input int nwords, input logic rnd, input logic auto_d, input int budget);
    int start = n_acc;
    int cyc = 0;
    while (n_acc - start < nwords && cyc < budget) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, auto_d);
      cyc++;
    end
    chk("word_count", 256'(n_acc - start), 256'(nwords));
  endtask

  task automatic idle_check(input int n, input logic exp_ovf);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    chk("idle_valid", 256'(mif.m_valid), 256'(0));
    chk("idle_busy",  256'(busy), 256'(0));
    chk("idle_ovf",   256'(ovf_err), 256'(exp_ovf));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; bank_done = 1'b0; mif.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_trackers();
  endtask

  initial begin
    int s0, f0;
    mif.m_ready = 1'b0;
    do_reset();

    // single half, full rate
    f0 = nfree;
    step(1'b1, 1'b1, 1'b0);
    s0 = stp;
    collect(HALF, 1'b0, 1'b0, 400);
    chk("t1_latency",    256'(first_valid - s0), 256'(LAT_EXP));
    chk("t1_throughput", 256'(last_acc - first_valid), 256'(HALF - 1));
    chk("t1_nfree",      256'(nfree - f0), 256'(1));
    step(1'b1, 1'b0, 1'b0);
    chk("t1_busy", 256'(busy), 256'(0));

    // two halves back to back, continuing in bank 1 then wrapping to bank 0
    f0 = nfree;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    collect(2 * HALF, 1'b0, 1'b0, 800);
    chk("t2_nfree", 256'(nfree - f0), 256'(2));
    idle_check(10, 1'b0);

    // random backpressure
    step(1'b0, 1'b1, 1'b0);
    collect(HALF, 1'b1, 1'b0, 3000);
    idle_check(10, 1'b0);

    // overflow: third done while two halves are pending
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t4_ovf_set", 256'(ovf_err), 256'(1));
    f0 = nfree;
    collect(2 * HALF, 1'b0, 1'b0, 800);
    chk("t4_nfree", 256'(nfree - f0), 256'(2));
    idle_check(40, 1'b1);

    // done coinciding with free at pending=2 is accepted without error
    do_reset();
    auto_used = 1'b0;
    f0 = nfree;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    collect(3 * HALF, 1'b0, 1'b1, 1200);
    chk("t4b_auto_fired", 256'(auto_used), 256'(1));
    chk("t4b_nfree", 256'(nfree - f0), 256'(3));
    idle_check(40, 1'b0);

    // reset in the middle of a half
    f0 = nfree;
    step(1'b1, 1'b1, 1'b0);
    collect(60, 1'b0, 1'b0, 200);
    #2 rst_n = 1'b0;
    #1 reset_values("midrst");
    chk("midrst_nfree", 256'(nfree - f0), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_trackers();
    step(1'b1, 1'b1, 1'b0);
    s0 = stp;
    collect(HALF, 1'b0, 1'b0, 400);
    chk("t5_latency", 256'(first_valid - s0), 256'(LAT_EXP));
    chk("t5_nfree",   256'(nfree - f0), 256'(1));
    idle_check(5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
